axi4l_csr_bank: RTL and testbench

AXI4L_CSR_BANK -- requirements
Module: axi4l_csr_bank

---
 rtl/axi4l_csr_bank_if.sv | 48 ++++
 rtl/axi4l_csr_bank.sv | 233 +++++++++++++++++++++++
 tb/tb_axi4l_csr_bank.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4l_csr_bank_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R) between a master and the CSR bank.
// Latency: none, wiring only.
// Backpressure: plain AXI valid/ready on each of the five channels.
interface axi4l_csr_bank_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // write address channel
    logic [ADDR_WIDTH-1:0]   AXI_AWADDR;
    logic [2:0]              AXI_AWPROT;
    logic                    AXI_AWVALID;
    logic                    AXI_AWREADY;
    // write data channel
    logic [DATA_WIDTH-1:0]   AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] AXI_WSTRB;
    logic                    AXI_WVALID;
    logic                    AXI_WREADY;
    // write response channel
    logic [1:0]              AXI_BRESP;
    logic                    AXI_BVALID;
    logic                    AXI_BREADY;
    // read address channel
    logic [ADDR_WIDTH-1:0]   AXI_ARADDR;
    logic [2:0]              AXI_ARPROT;
    logic                    AXI_ARVALID;
    logic                    AXI_ARREADY;
    // read data channel
    logic [DATA_WIDTH-1:0]   AXI_RDATA;
    logic [1:0]              AXI_RRESP;
    logic                    AXI_RVALID;
    logic                    AXI_RREADY;

    modport master (
        output AXI_AWADDR, AXI_AWPROT, AXI_AWVALID, input AXI_AWREADY,
        output AXI_WDATA, AXI_WSTRB, AXI_WVALID,    input AXI_WREADY,
        input  AXI_BRESP, AXI_BVALID,               output AXI_BREADY,
        output AXI_ARADDR, AXI_ARPROT, AXI_ARVALID, input AXI_ARREADY,
        input  AXI_RDATA, AXI_RRESP, AXI_RVALID,    output AXI_RREADY
    );

    modport slave (
        input  AXI_AWADDR, AXI_AWPROT, AXI_AWVALID, output AXI_AWREADY,
        input  AXI_WDATA, AXI_WSTRB, AXI_WVALID,    output AXI_WREADY,
        output AXI_BRESP, AXI_BVALID,               input AXI_BREADY,
        input  AXI_ARADDR, AXI_ARPROT, AXI_ARVALID, output AXI_ARREADY,
        output AXI_RDATA, AXI_RRESP, AXI_RVALID,    input AXI_RREADY
    );
endinterface

// File: rtl/axi4l_csr_bank.sv
// AXI4-Lite CSR bank: NUM_REGS word-addressed R/W registers with byte strobes and write pulses.
// Latency: BVALID one cycle after the later of AW/W handshakes; RVALID one cycle after AR.
// Backpressure: B and R held stable until BREADY/RREADY; one write and one read per 2 cycles.
module axi4l_csr_bank #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           CLK,
    input  logic                           RST,
    axi4l_csr_bank_if.slave                s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] REGS_OUT,
    output logic [NUM_REGS-1:0]            WR_PULSE
);

    localparam int         STRB_W      = DATA_WIDTH / 8;
    localparam int         IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    // register array
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    // write side state and registered outputs
    wstate_t               r_wstate;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic [NUM_REGS-1:0]   r_wr_pulse;

    // read side state and registered outputs
    rstate_t               r_rstate;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    // handshakes: ready is only ever high in states that may accept that channel
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    assign w_aw_hs = s_axi.AXI_AWVALID & r_awready;
    assign w_w_hs  = s_axi.AXI_WVALID  & r_wready;
    assign w_ar_hs = s_axi.AXI_ARVALID & r_arready;

    // write operands come straight off the bus when that channel handshakes this cycle,
    // otherwise from the copy latched on the earlier handshake
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_W-1:0]     w_wr_strb;
    assign w_wr_addr = w_aw_hs ? s_axi.AXI_AWADDR : r_awaddr;
    assign w_wr_data = w_w_hs  ? s_axi.AXI_WDATA  : r_wdata;
    assign w_wr_strb = w_w_hs  ? s_axi.AXI_WSTRB  : r_wstrb;

    // commit happens on the edge where the second of the two halves arrives
    logic                  w_commit;
    assign w_commit = (r_wstate == W_IDLE      && w_aw_hs && w_w_hs) ||
                      (r_wstate == W_HAVE_ADDR && w_w_hs) ||
                      (r_wstate == W_HAVE_DATA && w_aw_hs);

    // full-width range checks so aliased high addresses are rejected
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [NUM_REGS-1:0]   w_wr_onehot;
    assign w_wr_in_range = (w_wr_addr < ADDR_WIDTH'(NUM_REGS));
    assign w_rd_in_range = (s_axi.AXI_ARADDR < ADDR_WIDTH'(NUM_REGS));
    assign w_wr_idx      = w_wr_addr[IDX_W-1:0];
    assign w_rd_idx      = s_axi.AXI_ARADDR[IDX_W-1:0];
    assign w_wr_onehot   = w_wr_in_range ? (NUM_REGS'(1) << w_wr_idx) : '0;

    // protection bits carry no meaning for this bank
    logic                  w_unused;
    assign w_unused = &{1'b0, s_axi.AXI_AWPROT, s_axi.AXI_ARPROT};

    // Write FSM: collects AW and W in either order, commits, then holds B until accepted
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wstate   <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_aw_hs) begin
                r_awaddr <= s_axi.AXI_AWADDR;
            end
            if (w_w_hs) begin
                r_wdata <= s_axi.AXI_WDATA;
                r_wstrb <= s_axi.AXI_WSTRB;
            end
            if (w_commit) begin
                r_wstate   <= W_RESP;
                r_awready  <= 1'b0;
                r_wready   <= 1'b0;
                r_bvalid   <= 1'b1;
                r_bresp    <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
                r_wr_pulse <= w_wr_onehot;
            end else begin
                case (r_wstate)
                    W_IDLE: begin
                        if (w_aw_hs) begin
                            r_wstate  <= W_HAVE_ADDR;
                            r_awready <= 1'b0;
                            r_wready  <= 1'b1;
                        end else if (w_w_hs) begin
                            r_wstate  <= W_HAVE_DATA;
                            r_awready <= 1'b1;
                            r_wready  <= 1'b0;
                        end else begin
                            // also the path that raises both readies right after reset
                            r_awready <= 1'b1;
                            r_wready  <= 1'b1;
                        end
                    end
                    W_HAVE_ADDR: begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                    end
                    W_HAVE_DATA: begin
                        r_awready <= 1'b1;
                        r_wready  <= 1'b0;
                    end
                    W_RESP: begin
                        if (s_axi.AXI_BREADY) begin
                            r_wstate  <= W_IDLE;
                            r_bvalid  <= 1'b0;
                            r_awready <= 1'b1;
                            r_wready  <= 1'b1;
                        end
                    end
                    default: begin
                        r_wstate  <= W_IDLE;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_bvalid  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Register array: byte-strobed update on an in-range commit
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VALUE;
            end
        end else if (w_commit && w_wr_in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_wr_strb[b]) begin
                    r_regs[w_wr_idx][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Read FSM: samples the array on AR (pre-write value on a same-edge commit), holds R until taken
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate  <= R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_in_range ? r_regs[w_rd_idx] : '0;
                        r_rresp   <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi.AXI_RREADY) begin
                        r_rstate  <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b0;
                end
            endcase
        end
    end

    // flat view of the array for downstream logic
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign REGS_OUT[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end

    assign WR_PULSE          = r_wr_pulse;
    assign s_axi.AXI_AWREADY = r_awready;
    assign s_axi.AXI_WREADY  = r_wready;
    assign s_axi.AXI_BVALID  = r_bvalid;
    assign s_axi.AXI_BRESP   = r_bresp;
    assign s_axi.AXI_ARREADY = r_arready;
    assign s_axi.AXI_RVALID  = r_rvalid;
    assign s_axi.AXI_RDATA   = r_rdata;
    assign s_axi.AXI_RRESP   = r_rresp;

endmodule

// File: tb/tb_axi4l_csr_bank.sv
// Bench for the AXI4-Lite CSR bank: directed corner cases then randomized traffic against a register model.
// Latency: checks BVALID/RVALID timing relative to the handshakes.
// Backpressure: exercises held BREADY and same-edge read/write.
module tb_axi4l_csr_bank;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;

    logic            CLK = 1'b0;
    logic            RST;
    logic [NR*DW-1:0] REGS_OUT;
    logic [NR-1:0]   WR_PULSE;

    axi4l_csr_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi4l_csr_bank #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .RESET_VALUE('0)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .s_axi   (axi),
        .REGS_OUT(REGS_OUT),
        .WR_PULSE(WR_PULSE)
    );

    always #5 CLK = ~CLK;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] m_regs [NR];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        logic [NR*DW-1:0] exp;
        for (int i = 0; i < NR; i++) exp[i*DW +: DW] = m_regs[i];
        n_vec++;
        assert (REGS_OUT === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, REGS_OUT, exp);
        end
    endtask

    // reference: a word array where only strobed bytes of in-range words change
    function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a < NR) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) m_regs[a][b*8 +: 8] = d[b*8 +: 8];
            end
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
    endfunction

    task automatic aw_hs(input logic [31:0] a);
        bit ok = 0;
        axi.AXI_AWADDR  = a;
        axi.AXI_AWVALID = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK);
            ok = axi.AXI_AWREADY;
        end
        chk("awready_seen", 64'(ok), 64'd1);
        @(posedge CLK); #1;
        axi.AXI_AWVALID = 1'b0;
    endtask

    task automatic w_hs(input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        axi.AXI_WDATA  = d;
        axi.AXI_WSTRB  = s;
        axi.AXI_WVALID = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK);
            ok = axi.AXI_WREADY;
        end
        chk("wready_seen", 64'(ok), 64'd1);
        @(posedge CLK); #1;
        axi.AXI_WVALID = 1'b0;
    endtask

    task automatic both_hs(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        axi.AXI_AWADDR  = a;
        axi.AXI_WDATA   = d;
        axi.AXI_WSTRB   = s;
        axi.AXI_AWVALID = 1'b1;
        axi.AXI_WVALID  = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK);
            ok = axi.AXI_AWREADY & axi.AXI_WREADY;
        end
        chk("aw_w_ready_seen", 64'(ok), 64'd1);
        @(posedge CLK); #1;
        axi.AXI_AWVALID = 1'b0;
        axi.AXI_WVALID  = 1'b0;
    endtask

    task automatic b_take(output logic [1:0] resp);
        bit ok = 0;
        axi.AXI_BREADY = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK);
            ok = axi.AXI_BVALID;
        end
        chk("bvalid_seen", 64'(ok), 64'd1);
        resp = axi.AXI_BRESP;
        @(posedge CLK); #1;
        axi.AXI_BREADY = 1'b0;
    endtask

    task automatic r_take(output logic [31:0] d, output logic [1:0] resp);
        bit ok = 0;
        axi.AXI_RREADY = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK);
            ok = axi.AXI_RVALID;
        end
        chk("rvalid_seen", 64'(ok), 64'd1);
        d    = axi.AXI_RDATA;
        resp = axi.AXI_RRESP;
        @(posedge CLK); #1;
        axi.AXI_RREADY = 1'b0;
    endtask

    task automatic ar_hs(input logic [31:0] a);
        bit ok = 0;
        axi.AXI_ARADDR  = a;
        axi.AXI_ARVALID = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK);
            ok = axi.AXI_ARREADY;
        end
        chk("arready_seen", 64'(ok), 64'd1);
        @(posedge CLK); #1;
        axi.AXI_ARVALID = 1'b0;
    endtask

    // read and compare against the model; out-of-range reads return zero with SLVERR
    task automatic read_chk(input logic [31:0] a);
        logic [31:0] d;
        logic [1:0]  r;
        ar_hs(a);
        chk("rvalid_latency", 64'(axi.AXI_RVALID), 64'd1);
        r_take(d, r);
        chk("rdata", 64'(d), (a < NR) ? 64'(m_regs[a]) : 64'd0);
        chk("rresp", 64'(r), (a < NR) ? 64'd0 : 64'd2);
    endtask

    // mode 0: AW+W together, 1: AW then W, 2: W then AW, 3: W, idle cycle, AW
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int mode);
        logic [1:0]    r;
        logic [NR-1:0] ep;
        case (mode)
            0: both_hs(a, d, s);
            1: begin aw_hs(a); chk("bvalid_early", 64'(axi.AXI_BVALID), 64'd0); w_hs(d, s); end
            2: begin w_hs(d, s); chk("bvalid_early", 64'(axi.AXI_BVALID), 64'd0); aw_hs(a); end
            default: begin
                w_hs(d, s);
                @(posedge CLK); #1;
                chk("bvalid_early", 64'(axi.AXI_BVALID), 64'd0);
                aw_hs(a);
            end
        endcase
        chk("bvalid_latency", 64'(axi.AXI_BVALID), 64'd1);
        ep = (a < NR) ? (NR'(1) << a) : '0;
        chk("wr_pulse", 64'(WR_PULSE), 64'(ep));
        m_write(a, d, s);
        @(posedge CLK); #1;
        chk("wr_pulse_clear", 64'(WR_PULSE), 64'd0);
        b_take(r);
        chk("bresp", 64'(r), (a < NR) ? 64'd0 : 64'd2);
        chk_regs("regs_after_write");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        logic [1:0]  r;

        axi.AXI_AWADDR  = '0; axi.AXI_AWPROT = '0; axi.AXI_AWVALID = 1'b0;
        axi.AXI_WDATA   = '0; axi.AXI_WSTRB  = '0; axi.AXI_WVALID  = 1'b0;
        axi.AXI_BREADY  = 1'b0;
        axi.AXI_ARADDR  = '0; axi.AXI_ARPROT = '0; axi.AXI_ARVALID = 1'b0;
        axi.AXI_RREADY  = 1'b0;
        RST = 1'b1;
        m_reset();

        // reset state
        #22;
        chk("rst_awready", 64'(axi.AXI_AWREADY), 64'd0);
        chk("rst_wready",  64'(axi.AXI_WREADY),  64'd0);
        chk("rst_arready", 64'(axi.AXI_ARREADY), 64'd0);
        chk("rst_bvalid",  64'(axi.AXI_BVALID),  64'd0);
        chk("rst_rvalid",  64'(axi.AXI_RVALID),  64'd0);
        chk("rst_bresp",   64'(axi.AXI_BRESP),   64'd0);
        chk("rst_rresp",   64'(axi.AXI_RRESP),   64'd0);
        chk("rst_rdata",   64'(axi.AXI_RDATA),   64'd0);
        chk("rst_wr_pulse", 64'(WR_PULSE),       64'd0);
        chk_regs("rst_regs");
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("post_rst_awready", 64'(axi.AXI_AWREADY), 64'd1);
        chk("post_rst_wready",  64'(axi.AXI_WREADY),  64'd1);
        chk("post_rst_arready", 64'(axi.AXI_ARREADY), 64'd1);

        // AW and W together to reg3
        do_write(32'd3, 32'hDEADBEEF, 4'hF, 0);
        chk("reg3_value", 64'(REGS_OUT[3*DW +: DW]), 64'hDEADBEEF);

        // W two cycles ahead of AW, partial strobe over zero
        do_write(32'd5, 32'h12345678, 4'h5, 3);
        chk("reg5_value", 64'(REGS_OUT[5*DW +: DW]), 64'h00340078);

        // out-of-range write and read
        do_write(32'd16, 32'hFFFFFFFF, 4'hF, 0);
        read_chk(32'd16);

        // held BREADY: response and readies frozen for five cycles
        both_hs(32'd9, 32'hCAFEF00D, 4'hF);
        m_write(32'd9, 32'hCAFEF00D, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("hold_bvalid",  64'(axi.AXI_BVALID),  64'd1);
            chk("hold_bresp",   64'(axi.AXI_BRESP),   64'd0);
            chk("hold_awready", 64'(axi.AXI_AWREADY), 64'd0);
            chk("hold_wready",  64'(axi.AXI_WREADY),  64'd0);
        end
        @(posedge CLK); #1;
        axi.AXI_BREADY = 1'b1;
        @(posedge CLK); #1;
        axi.AXI_BREADY = 1'b0;
        chk("after_b_bvalid",  64'(axi.AXI_BVALID),  64'd0);
        chk("after_b_awready", 64'(axi.AXI_AWREADY), 64'd1);
        chk("after_b_wready",  64'(axi.AXI_WREADY),  64'd1);
        do_write(32'd10, 32'h0BADC0DE, 4'hF, 0);

        // same-edge write commit and read of reg2 returns the old value
        do_write(32'd2, 32'hAAAA5555, 4'hF, 0);
        @(negedge CLK);
        chk("pre_same_ready", 64'({axi.AXI_AWREADY, axi.AXI_WREADY, axi.AXI_ARREADY}), 64'd7);
        @(posedge CLK); #1;
        axi.AXI_AWADDR = 32'd2; axi.AXI_WDATA = 32'h11111111; axi.AXI_WSTRB = 4'hF;
        axi.AXI_ARADDR = 32'd2;
        axi.AXI_AWVALID = 1'b1; axi.AXI_WVALID = 1'b1; axi.AXI_ARVALID = 1'b1;
        @(posedge CLK); #1;
        axi.AXI_AWVALID = 1'b0; axi.AXI_WVALID = 1'b0; axi.AXI_ARVALID = 1'b0;
        chk("same_bvalid", 64'(axi.AXI_BVALID), 64'd1);
        chk("same_rvalid", 64'(axi.AXI_RVALID), 64'd1);
        chk("same_rdata",  64'(axi.AXI_RDATA),  64'hAAAA5555);
        chk("same_rresp",  64'(axi.AXI_RRESP),  64'd0);
        m_write(32'd2, 32'h11111111, 4'hF);
        b_take(r);
        chk("same_bresp", 64'(r), 64'd0);
        r_take(d, r);
        read_chk(32'd2);

        // reset while an address is held, no write or response may survive
        aw_hs(32'd7);
        #2;
        RST = 1'b1;
        #1;
        m_reset();
        chk("midrst_bvalid",  64'(axi.AXI_BVALID),  64'd0);
        chk("midrst_awready", 64'(axi.AXI_AWREADY), 64'd0);
        chk("midrst_wready",  64'(axi.AXI_WREADY),  64'd0);
        chk_regs("midrst_regs");
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("midrst_post_bvalid", 64'(axi.AXI_BVALID), 64'd0);
        do_write(32'd7, 32'h5A5A5A5A, 4'hF, 2);
        read_chk(32'd7);

        // randomized traffic, including aliased high addresses
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 7) == 0) a = 32'h0001_0000 | 32'($urandom_range(0, 15));
            else                           a = 32'($urandom_range(0, 17));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            do_write(a, d, s, int'($urandom_range(0, 3)));
            read_chk(32'($urandom_range(0, 17)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
